// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter merging PORTS cache memory ports onto one 128-bit Avalon-MM master.
// Grants one port per transfer; one idle bubble separates consecutive grants.
module cache_mem_arbiter #(
  parameter int unsigned PORTS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0][31:0]   cache_address,
  input  logic [PORTS-1:0]         cache_read,
  input  logic [PORTS-1:0]         cache_write,
  input  logic [PORTS-1:0][127:0]  cache_writedata,
  input  logic [PORTS-1:0][15:0]   cache_byteenable,
  output logic [PORTS-1:0]         cache_waitrequest,
  output logic [127:0]             cache_readdata,
  output logic [31:0]              mem_address,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [127:0]             mem_writedata,
  output logic [15:0]              mem_byteenable,
  input  logic                     mem_waitrequest,
  input  logic [127:0]             mem_readdata
);

  localparam int unsigned PW = $clog2(PORTS);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PORTS-1:0] req_c;
  logic [PW-1:0]    pick_c;
  logic             any_req_c;

  assign req_c = cache_read | cache_write;

  // Payload always follows the granted port; readdata is broadcast.
  assign mem_address    = cache_address[grant_q];
  assign mem_writedata  = cache_writedata[grant_q];
  assign mem_byteenable = cache_byteenable[grant_q];
  assign cache_readdata = mem_readdata;

  // First requester at or after ptr, wrapping; scanning downward lets the nearest one win.
  always_comb begin : rr_search
    logic [PW-1:0] cand;
    cand      = '0;
    pick_c    = ptr_q;
    any_req_c = 1'b0;
    for (int unsigned k = PORTS; k > 0; k--) begin
      cand = PW'((32'(ptr_q) + k - 32'd1) % PORTS);
      if (req_c[cand]) begin
        pick_c    = cand;
        any_req_c = 1'b1;
      end
    end
  end

  always_comb begin : fsm_next
    state_d           = state_q;
    grant_d           = grant_q;
    ptr_d             = ptr_q;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    cache_waitrequest = '1;
    unique case (state_q)
      IDLE: begin
        if (any_req_c) begin
          grant_d = pick_c;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_read                   = cache_read[grant_q];
        mem_write                  = cache_write[grant_q];
        cache_waitrequest[grant_q] = mem_waitrequest;
        if (!req_c[grant_q]) begin
          // Requester abandoned the transfer: give up without advancing fairness.
          state_d = IDLE;
        end else if (!mem_waitrequest) begin
          state_d = IDLE;
          ptr_d   = (grant_q == PW'(PORTS - 1)) ? '0 : grant_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_reg
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Upstream protocol checks.
  always_ff @(posedge clk) begin : proto_chk
    if (rst_n) begin
      a_no_rd_wr : assert ((cache_read & cache_write) == '0);
      a_req_hold : assert (!(state_q == BUSY && !req_c[grant_q]));
    end
  end

endmodule
